// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes, register
// index sentinel and the writeback state enum.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] ICMOVQ  = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE   = 4'hF;

  typedef enum logic [2:0] {
    SAOK = 3'd1,
    SHLT = 3'd2,
    SADR = 3'd3,
    SINS = 3'd4
  } stat_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

endpackage

// File: rtl/y86_regfile.sv
// Program register file: two write ports (M has priority over E on the
// same index), two combinational read ports, synchronous reset loads each
// register with its own index. Indices at or above NREG are ignored on
// write and read back as zero.
module y86_regfile #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned NREG   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_e,
  input  logic [3:0]        dst_e,
  input  logic [DATA_W-1:0] val_e,
  input  logic              we_m,
  input  logic [3:0]        dst_m,
  input  logic [DATA_W-1:0] val_m,
  input  logic [3:0]        src_a,
  input  logic [3:0]        src_b,
  output logic [DATA_W-1:0] rval_a,
  output logic [DATA_W-1:0] rval_b
);

  logic [DATA_W-1:0] regs [NREG];

  // Register update: reset-to-index, otherwise M port wins over E port
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NREG; i++) begin
      if (!rst_n)
        regs[i] <= DATA_W'(i);
      else if (we_m && dst_m == 4'(i))
        regs[i] <= val_m;
      else if (we_e && dst_e == 4'(i))
        regs[i] <= val_e;
    end
  end

  // Read ports: decode by scan so out-of-range indices return zero
  always_comb begin
    rval_a = '0;
    rval_b = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (src_a == 4'(i)) rval_a = regs[i];
      if (src_b == 4'(i)) rval_b = regs[i];
    end
  end

endmodule

// File: rtl/writeback.sv
// Y86-64 writeback stage: commits valE/valM to the register file, counts
// retired instructions and halts on HLT/ADR/INS until reset.
// Optional macro WRITEBACK_BYPASS_EN forwards same-cycle write data to the
// read ports (valM before valE).
module writeback
  import y86_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned NREG   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic [3:0]        icode,
  input  logic              cnd,
  input  logic [3:0]        dstE,
  input  logic [3:0]        dstM,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  input  logic [2:0]        stat,
  input  logic [3:0]        srcA,
  input  logic [3:0]        srcB,
  output logic [DATA_W-1:0] rvalA,
  output logic [DATA_W-1:0] rvalB,
  output logic              halted,
  output logic [63:0]       retired
);

  state_t            state;
  logic [3:0]        dste_eff;
  logic              commit;
  logic              we_e;
  logic              we_m;
  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;

  // Effective destination and write enables; reset blocks any write
  always_comb begin
    dste_eff = (icode == ICMOVQ && !cnd) ? RNONE : dstE;
    commit   = rst_n && (state == RUN) && wb_valid && (stat == SAOK);
    we_e     = commit && (dste_eff != RNONE) && (32'(dste_eff) < NREG);
    we_m     = commit && (dstM != RNONE) && (32'(dstM) < NREG);
  end

  y86_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_e   (we_e),
    .dst_e  (dste_eff),
    .val_e  (valE),
    .we_m   (we_m),
    .dst_m  (dstM),
    .val_m  (valM),
    .src_a  (srcA),
    .src_b  (srcB),
    .rval_a (rf_a),
    .rval_b (rf_b)
  );

`ifdef WRITEBACK_BYPASS_EN
  // Read ports with same-cycle forwarding, M write data first
  always_comb begin
    rvalA = rf_a;
    rvalB = rf_b;
    if (we_m && dstM == srcA)          rvalA = valM;
    else if (we_e && dste_eff == srcA) rvalA = valE;
    if (we_m && dstM == srcB)          rvalB = valM;
    else if (we_e && dste_eff == srcB) rvalB = valE;
  end
`else
  // Read ports straight from stored register state
  always_comb begin
    rvalA = rf_a;
    rvalB = rf_b;
  end
`endif

  // RUN/HALT control with retire counter; HALT is left only through reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= RUN;
      halted  <= 1'b0;
      retired <= '0;
    end else begin
      case (state)
        RUN: begin
          if (wb_valid) begin
            case (stat)
              SAOK: retired <= retired + 64'd1;
              SHLT: begin
                retired <= retired + 64'd1;
                state   <= HALT;
                halted  <= 1'b1;
              end
              default: begin
                state  <= HALT;
                halted <= 1'b1;
              end
            endcase
          end
        end
        default: begin
          state  <= HALT;
          halted <= 1'b1;
        end
      endcase
    end
  end

endmodule
